// File: rtl/fdiv_seq_if.sv
// Handshake bundle for the iterative fp32 divider: operand side (in_*)
// and result side (out_*), both valid/ready.
interface fdiv_seq_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
);
   localparam int W = 1 + EXP_W + MANT_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] num1;
   logic [W-1:0] num2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_div;
   logic         div_by_zero;

   modport master (
      output in_valid, num1, num2, out_ready,
      input  in_ready, out_valid, out_div, div_by_zero
   );

   modport slave (
      input  in_valid, num1, num2, out_ready,
      output in_ready, out_valid, out_div, div_by_zero
   );
endinterface

// File: rtl/fdiv_seq.sv
// Iterative simplified-fp32 divider (no denormals, truncation, wrapping
// exponent): restoring division producing one quotient bit per clock.
module fdiv_seq #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int BIAS   = 127
) (
   input logic       clk,
   input logic       rst_n,
   fdiv_seq_if.slave bus
);
   localparam int W     = 1 + EXP_W + MANT_W;
   localparam int CNT_W = $clog2(MANT_W + 2);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MANT_W + 1);

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                sign;
   logic [EXP_W-1:0]    e1;
   logic [EXP_W-1:0]    e2;
   logic [MANT_W:0]     m2;
   logic [MANT_W+1:0]   r;
   logic [MANT_W+1:0]   q;
   logic [CNT_W-1:0]    cnt;
   logic [W-1:0]        out_div_q;
   logic                dbz_q;

   logic                accept;
   logic                num1_zero;
   logic                num2_zero;
   logic                ge;
   logic [MANT_W+1:0]   r_sub;
   logic [EXP_W-1:0]    exp_raw;
   logic [EXP_W-1:0]    exp_norm;
   logic [MANT_W-1:0]   mant;

   assign accept    = bus.in_valid && (state == IDLE);
   assign num1_zero = (bus.num1 == '0);
   assign num2_zero = (bus.num2 == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) state_nxt = (num1_zero || num2_zero) ? DONE : DIV;
         DIV:  if (cnt == LAST_ITER) state_nxt = NORM;
         NORM: state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Quotient bit, remainder update and normalisation of the finished quotient.
   // The remainder stays below 2*m2, so the post-subtract shift never overflows.
   always_comb begin
      ge       = (r >= {1'b0, m2});
      r_sub    = ge ? (r - {1'b0, m2}) : r;
      exp_raw  = e1 - e2 + EXP_W'(BIAS);
      mant     = q[MANT_W-1:0];
      exp_norm = exp_raw - EXP_W'(1);
      if (q[MANT_W+1]) begin
         mant     = q[MANT_W:1];
         exp_norm = exp_raw;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign      <= 1'b0;
         e1        <= '0;
         e2        <= '0;
         m2        <= '0;
         r         <= '0;
         q         <= '0;
         cnt       <= '0;
         out_div_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign <= bus.num1[W-1] ^ bus.num2[W-1];
               e1   <= bus.num1[W-2:MANT_W];
               e2   <= bus.num2[W-2:MANT_W];
               m2   <= {1'b1, bus.num2[MANT_W-1:0]};
               r    <= {2'b01, bus.num1[MANT_W-1:0]};
               q    <= '0;
               cnt  <= '0;
               if (num2_zero) begin
                  out_div_q <= {bus.num1[W-1] ^ bus.num2[W-1], {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                  dbz_q     <= 1'b1;
               end else if (num1_zero) begin
                  out_div_q <= '0;
                  dbz_q     <= 1'b0;
               end
            end
            DIV: begin
               r   <= r_sub << 1;
               q   <= {q[MANT_W:0], ge};
               cnt <= cnt + CNT_W'(1);
            end
            NORM: begin
               out_div_q <= {sign, exp_norm, mant};
               dbz_q     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.out_div     = out_div_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed vectors plus a scoreboard
// driven by an arithmetic reference model, compared every cycle.
module tb_fdiv_seq;
   logic clk;
   logic rst_n;
   int   cycle;
   int   testsRun;
   int   testsFailed;

   fdiv_seq_if #(.EXP_W(8), .MANT_W(23)) bus ();

   fdiv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        dbz;
      int          readyCycle;
   } exp_t;

   exp_t sb[$];
   logic modelIdle;
   logic expValid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [31:0] refDiv(input logic [31:0] a, input logic [31:0] b);
      logic       s;
      longint     m1;
      longint     m2;
      longint     qv;
      int         e;
      logic [22:0] mv;
      s = a[31] ^ b[31];
      if (b == 32'd0) return {s, 8'hFF, 23'd0};
      if (a == 32'd0) return 32'd0;
      m1 = longint'({1'b1, a[22:0]});
      m2 = longint'({1'b1, b[22:0]});
      qv = (m1 << 24) / m2;
      e  = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (qv >= (longint'(1) << 24)) begin
         mv = 23'(qv >> 1);
      end else begin
         mv = 23'(qv);
         e  = e - 1;
      end
      return {s, 8'(e), mv};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.num1     = a;
      bus.num2     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic runDirected(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expRes, input logic expDbz);
      logic got;
      applyStimulus(a, b);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput({name, " valid"}, {31'd0, got}, 32'd1);
      if (got) begin
         checkOutput(name, bus.out_div, expRes);
         checkOutput({name, " dbz"}, {31'd0, bus.div_by_zero}, {31'd0, expDbz});
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: the model is busy from accept until the result handshake,
   // and the result must appear exactly at the architectural latency.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         checkOutput("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
         checkOutput("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
         modelIdle = (sb.size() == 0);
         expValid  = !modelIdle && (cycle >= sb[0].readyCycle);
         checkOutput("mon in_ready", {31'd0, bus.in_ready}, {31'd0, modelIdle});
         checkOutput("mon out_valid", {31'd0, bus.out_valid}, {31'd0, expValid});
         if (expValid) begin
            checkOutput("mon out_div", bus.out_div, sb[0].res);
            checkOutput("mon dbz", {31'd0, bus.div_by_zero}, {31'd0, sb[0].dbz});
            if (bus.out_ready) void'(sb.pop_front());
         end
         if (modelIdle && bus.in_valid) begin
            if (bus.num1 == 32'd0 || bus.num2 == 32'd0)
               sb.push_back('{refDiv(bus.num1, bus.num2), bus.num2 == 32'd0, cycle + 1});
            else
               sb.push_back('{refDiv(bus.num1, bus.num2), 1'b0, cycle + 27});
         end
      end
   end

   initial begin
      logic        got;
      logic [31:0] a;
      logic [31:0] b;
      cycle         = 0;
      testsRun      = 0;
      testsFailed   = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.num1      = 32'd0;
      bus.num2      = 32'd0;
      bus.out_ready = 1'b1;

      #2;
      checkOutput("reset out_div", bus.out_div, 32'd0);
      checkOutput("reset dbz", {31'd0, bus.div_by_zero}, 32'd0);
      checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

      checkOutput("model 6/2", refDiv(32'h40C00000, 32'h40000000), 32'h40400000);
      checkOutput("model 1/3", refDiv(32'h3F800000, 32'h40400000), 32'h3EAAAAAA);
      checkOutput("model -1.5/0.5", refDiv(32'hBFC00000, 32'h3F000000), 32'hC0400000);
      checkOutput("model x/0", refDiv(32'h40000000, 32'h00000000), 32'h7F800000);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      runDirected("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      runDirected("1/2", 32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0);
      runDirected("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
      runDirected("-1.5/0.5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0);
      runDirected("0/2", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0);
      runDirected("2/0", 32'h40000000, 32'h00000000, 32'h7F800000, 1'b1);
      runDirected("0/0", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1);
      runDirected("-2/0", 32'hC0000000, 32'h00000000, 32'hFF800000, 1'b1);
      runDirected("negzero/2", 32'h80000000, 32'h40000000, 32'hFF800000, 1'b0);
      runDirected("2/negzero", 32'h40000000, 32'h80000000, 32'hFF800000, 1'b0);

      // Result held under backpressure while new requests are ignored.
      bus.out_ready = 1'b0;
      applyStimulus(32'h40400000, 32'h3F800000);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("bp valid", {31'd0, got}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = i[0];
         bus.num1     = 32'h41000000;
         bus.num2     = 32'h40000000;
         @(negedge clk);
         checkOutput("bp hold", bus.out_div, 32'h40400000);
         checkOutput("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp idle", {31'd0, bus.in_ready}, 32'd1);
      runDirected("after bp", 32'h41200000, 32'h40A00000, 32'h40000000, 1'b0);

      // Abort in the middle of the iteration.
      applyStimulus(32'h40C00000, 32'h40000000);
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      runDirected("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         a = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
         b = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
         runDirected($sformatf("rand %0d", i), a, b, refDiv(a, b), 1'b0);
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Iterative single-precision floating-point divider: out = num1 / num2.
- Uses the same simplified fp32 format as the team's combinational multiplier, so results combine directly.
- Format rules: no denormals, no rounding (truncate), 8-bit exponent arithmetic wraps.
- Restoring division, one quotient bit per clock, valid/ready handshake on both sides; sits beside fmul in the arithmetic datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MANT_W.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider idle, can accept.
- num1  in  W  dividend.
- num2  in  W  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_div  out  W  quotient.
- div_by_zero  out  1  result came from a zero divisor; valid with out_valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, out_div=0, div_by_zero=0, iteration counter=0, datapath registers=0. in_ready=1 while in IDLE; it is decoded from state.
- States: IDLE, DIV, NORM, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch the operands and the result sign (num1[W-1]^num2[W-1]).
- Zero detection uses the whole-word compare (word==0); 0x80000000 is NOT zero.
  - num2==0 → out_div={sign, all-ones exp, 0 mant}, div_by_zero=1, go directly to DONE.
  - 0/0 takes this same path.
  - num1==0 (num2≠0) → out_div=0 (all bits, sign cleared), go directly to DONE.
  - Either special case: out_valid=1 in the cycle after the accept edge.
- Normal accept: m1={1,num1 mant}, m2={1,num2 mant} (MANT_W+1 bits); remainder r=m1 (MANT_W+2 bits wide); q=0; counter=0; go to DIV.
- DIV, one iteration per cycle:
  - If r>=m2: next q bit=1 and r=r-m2; else the bit=0.
  - Then r=r<<1; q shifts in MSB-first.
  - MANT_W+2 (=25) iterations; after the last, go to NORM.
- NORM (1 cycle):
  - exp_raw = e1 - e2 + BIAS, computed modulo 2^EXP_W (wrap, no saturation).
  - If q[MANT_W+1]=1: mant=q[MANT_W:1], exp=exp_raw.
  - Else: mant=q[MANT_W-1:0], exp=exp_raw-1.
  - Remaining quotient bits are truncated.
  - Register out_div={sign,exp,mant}, div_by_zero=0; go to DONE.
- DONE: out_valid=1; out_div and div_by_zero held stable until out_valid&out_ready.
  - On the handshake edge: go to IDLE, out_valid=0.
  - in_ready=0 in DONE, so there is no same-cycle re-accept.
- Latency for normal operands: accept edge + 25 DIV edges + 1 NORM edge; out_valid rises after the 27th rising edge counting the accept edge as the 1st. Throughput is one divide per ≥28 cycles.
- in_valid and operand changes while not in IDLE are ignored; operands are sampled only at accept.
- Reset mid-operation aborts immediately: out_valid drops asynchronously, and the partial result is never presented.
- Exponent underflow/overflow and NaN/Inf operand encodings get no special handling; they follow the wrap rules above.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) → out_div=0x40400000 after 27 edges, div_by_zero=0; 1.0/2.0 (0x3F800000/0x40000000) → 0x3F000000.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated, not 0x3EAAAAAB); 0xBFC00000 / 0x3F000000 → 0xC0400000.
- Zero cases:
  - 0x00000000 / 0x40000000 → 0x00000000 one cycle after accept.
  - 0x40000000 / 0 → 0x7F800000 with div_by_zero=1.
  - 0/0 → 0x7F800000 with div_by_zero=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_div stable, in_ready=0, new in_valid pulses ignored; out_ready=1 → IDLE next cycle, next operand pair accepted with a correct result.
- Deassert rst_n at DIV iteration 12 → out_valid=0, in_ready=1 immediately; after release, 6.0/2.0 yields 0x40400000 with the full 27-edge latency.
- Random regression: 1000 normal operand pairs with exponents 100..150 → bit-exact against a reference model applying the truncation and exp wrap rules above.
